adc_test_pattern_ctrl: RTL and testbench
========================================

// Module: adc_test_pattern_ctrl
// PURPOSE
//  SPI configuration master for the AD9252 ADC. Programs the user test pattern and test mode,
//  asserts ad_test_mode to the per-channel data-alignment FSMs, and waits for all channels to
//  report alignment. It then restores normal conversion mode. Sits between the slow-control
//  start register and the ADC SPI pins (SCLK/CSB/SDIO).
// PARAMETERS
//  SCLK_DIV       8         clk_ref cycles per SCLK half-period (>=2)
//  ALIGN_TIMEOUT  24'hFFFFFF clk_ref cycles to wait for dat_aligned before abort
//  TEST_MODE_CODE 8'h08     value written to reg 0x0D for user-pattern mode
// PORTS
//  clk_ref        in  1  clock; all logic on posedge
//  reset          in  1  asynchronous, active-high
//  start          in  1  1-cycle pulse; begins sequence when idle
//  test_pattern   in  14 pattern word, captured at start (default use 14'h2867)
//  dat_aligned    in  1  AND of all channel alignment flags
//  spi_sclk       out 1  SPI clock, idle low
//  spi_csb        out 1  SPI chip select, active low
//  spi_sdio_o     out 1  SDIO drive value
//  spi_sdio_oe    out 1  SDIO output enable (1 = drive)
//  spi_sdio_i     in  1  SDIO pad input (used only with readback)
//  ad_test_mode   out 1  ADC is outputting test pattern
//  busy           out 1  sequence in progress
//  done           out 1  1-cycle pulse at end of sequence
//  error          out 1  sticky; set on timeout or readback mismatch, cleared by next start
// BEHAVIOUR
//  Reset: spi_sclk=0, spi_csb=1, spi_sdio_o=0, spi_sdio_oe=0, ad_test_mode=0, busy=0, done=0,
//   error=0, state IDLE. Reset mid-frame aborts immediately; CSB high asynchronously.
//  Frame: 24 bits, MSB first = {R/W, W1:W0=2'b00, A[12:0], D[7:0]}.
//   LOAD: CSB falls, sdio=bit23, SCLK low. Each bit has SCLK low for SCLK_DIV cycles, then high
//   for SCLK_DIV cycles; SDIO changes only at the SCLK falling boundary.
//   After bit0 high phase: SCLK low for SCLK_DIV cycles, then CSB rises.
//   CSB low = 49*SCLK_DIV cycles. Inter-frame GAP: CSB high 2*SCLK_DIV cycles.
//   spi_sdio_oe=1 whenever CSB low (except readback data phase).
//  Command list (index 0..5):
//   0: W 0x19={test_pattern[5:0],2'b00}
//   1: W 0x1A=test_pattern[13:6]
//   2: W 0x0D=TEST_MODE_CODE
//   3: W 0xFF=0x01 (transfer)
//   4: W 0x0D=0x00
//   5: W 0xFF=0x01
//  FSM: IDLE -start-> LOAD -> SHIFT -> GAP -> LOAD(next idx) ...
//   After idx3 GAP: ad_test_mode<=1 -> WAIT_ALIGN.
//   WAIT_ALIGN: dat_aligned=1 -> ad_test_mode<=0, LOAD idx4.
//    Counter reaches ALIGN_TIMEOUT -> error<=1, ad_test_mode<=0, LOAD idx4.
//   After idx5 GAP -> DONE (done=1 one cycle, busy<=0) -> IDLE.
//  busy=1 from cycle after start until DONE.
//  start while busy: ignored; test_pattern is not recaptured.
//  dat_aligned is sampled only in WAIT_ALIGN; a level already high on entry completes in 1 cycle.
//  Timeout counter 24 bits, cleared on WAIT_ALIGN entry; no wrap (compare is ==).
// CONFIGURATION
//  ADC_SPI_READBACK_EN defined: after idx3 GAP, issue read frame R/W=1, addr 0x0D.
//   spi_sdio_oe=0 for the 8 data bits; spi_sdio_i sampled on each SCLK rising edge.
//   Readback == TEST_MODE_CODE: enter WAIT_ALIGN.
//   Mismatch: error<=1, ad_test_mode stays 0, jump to idx4.
//   Adds one frame + GAP.
//  Not defined: no read frame; spi_sdio_i ignored; idx3 GAP goes directly to WAIT_ALIGN.
// TESTING (SCLK_DIV=2, ALIGN_TIMEOUT=100)
//  start, pattern 14'h2867, dat_aligned high 50 cycles after ad_test_mode
//   -> 6 frames decode to 0x019/9C, 0x01A/A1, 0x00D/08, 0x0FF/01, 0x00D/00, 0x0FF/01;
//   done pulse; error=0.
//  Each frame: CSB low exactly 98 cycles, 24 SCLK rises, GAP 4 cycles.
//   SDIO stable around every SCLK rise.
//  dat_aligned never asserted -> ad_test_mode high 100 cycles, then restore frames; error=1, done=1.
//  reset asserted mid-frame 1 -> CSB=1, SCLK=0 same cycle; next start replays from idx0.
//  start pulsed during WAIT_ALIGN -> no effect; sequence unchanged.
//  READBACK_EN, spi_sdio_i returns 0x00 -> error=1, ad_test_mode never 1, idx4/5 still sent.

Source files
------------

// File: rtl/adc_test_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_test_pattern_ctrl
// Purpose  : AD9252 SPI sequencer: loads the user test pattern, enables test
//            mode, waits for channel alignment, then restores normal mode.
//            Optional feature macro: ADC_SPI_READBACK_EN (verifies reg 0x0D).
// Revision : 1.0 - initial release
// ============================================================================
module adc_test_pattern_ctrl #(
    parameter int          SCLK_DIV       = 8,
    parameter logic [23:0] ALIGN_TIMEOUT  = 24'hFFFFFF,
    parameter logic [7:0]  TEST_MODE_CODE = 8'h08
) (
    input  logic        clk_ref,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] test_pattern,
    input  logic        dat_aligned,
    output logic        spi_sclk,
    output logic        spi_csb,
    output logic        spi_sdio_o,
    output logic        spi_sdio_oe,
    input  logic        spi_sdio_i,
    output logic        ad_test_mode,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int              c_TW        = $clog2(2 * SCLK_DIV);
    localparam logic [c_TW-1:0] c_HALF_LAST = c_TW'(SCLK_DIV - 1);
    localparam logic [c_TW-1:0] c_GAP_LAST  = c_TW'(2 * SCLK_DIV - 2);
    localparam logic [c_TW-1:0] c_TICK_ONE  = c_TW'(1);
    localparam logic [5:0]      c_HALF_END  = 6'd48;
    localparam logic [5:0]      c_DATA_HALF = 6'd32;

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_LOAD       = 3'd1;
    localparam logic [2:0] c_SHIFT      = 3'd2;
    localparam logic [2:0] c_GAP        = 3'd3;
    localparam logic [2:0] c_WAIT_ALIGN = 3'd4;
    localparam logic [2:0] c_DONE       = 3'd5;

    logic [2:0]      r_state;
    logic [2:0]      r_idx;
    logic [13:0]     r_pattern;
    logic [22:0]     r_shift;
    logic [5:0]      r_half;
    logic [c_TW-1:0] r_tick;
    logic [23:0]     r_align_cnt;
    logic            r_sclk;
    logic            r_csb;
    logic            r_sdio_o;
    logic            r_sdio_oe;
    logic            r_test_mode;
    logic            r_busy;
    logic            r_done;
    logic            r_error;

    logic [23:0]     w_word;
    logic [5:0]      w_half_nxt;
    logic [23:0]     w_align_nxt;

`ifdef ADC_SPI_READBACK_EN
    logic            r_is_read;
    logic [7:0]      r_rdata;
`else
    logic            w_unused_sdio_i;
    assign w_unused_sdio_i = spi_sdio_i;
`endif

    // Frame = {R/W, W1:W0, A[12:0], D[7:0]}; index 6 is the optional read-back of 0x0D.
    function automatic logic [23:0] f_cmd(input logic [2:0] idx, input logic [13:0] pat);
        case (idx)
            3'd0:    f_cmd = {1'b0, 2'b00, 13'h0019, pat[5:0], 2'b00};
            3'd1:    f_cmd = {1'b0, 2'b00, 13'h001A, pat[13:6]};
            3'd2:    f_cmd = {1'b0, 2'b00, 13'h000D, TEST_MODE_CODE};
            3'd3:    f_cmd = {1'b0, 2'b00, 13'h00FF, 8'h01};
            3'd4:    f_cmd = {1'b0, 2'b00, 13'h000D, 8'h00};
            3'd5:    f_cmd = {1'b0, 2'b00, 13'h00FF, 8'h01};
            default: f_cmd = {1'b1, 2'b00, 13'h000D, 8'h00};
        endcase
    endfunction

    assign w_word      = f_cmd(r_idx, r_pattern);
    assign w_half_nxt  = r_half + 6'd1;
    assign w_align_nxt = r_align_cnt + 24'd1;

    always_ff @(posedge clk_ref or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_idx       <= 3'd0;
            r_pattern   <= 14'd0;
            r_shift     <= 23'd0;
            r_half      <= 6'd0;
            r_tick      <= '0;
            r_align_cnt <= 24'd0;
            r_sclk      <= 1'b0;
            r_csb       <= 1'b1;
            r_sdio_o    <= 1'b0;
            r_sdio_oe   <= 1'b0;
            r_test_mode <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef ADC_SPI_READBACK_EN
            r_is_read   <= 1'b0;
            r_rdata     <= 8'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_pattern <= test_pattern;
                        r_idx     <= 3'd0;
                        r_error   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_csb     <= 1'b0;
                    r_sclk    <= 1'b0;
                    r_sdio_o  <= w_word[23];
                    r_shift   <= w_word[22:0];
                    r_sdio_oe <= 1'b1;
                    r_half    <= 6'd0;
                    r_tick    <= '0;
`ifdef ADC_SPI_READBACK_EN
                    r_is_read <= (r_idx == 3'd6);
`endif
                    r_state   <= c_SHIFT;
                end
                c_SHIFT: begin
                    // Even halves are SCLK-low phases, odd halves high; half 48 is the CSB hold.
                    if (r_tick == c_HALF_LAST) begin
                        r_tick <= '0;
                        if (r_half == c_HALF_END) begin
                            r_csb     <= 1'b1;
                            r_sdio_oe <= 1'b0;
                            r_sdio_o  <= 1'b0;
                            r_state   <= c_GAP;
                        end else begin
                            r_half <= w_half_nxt;
                            r_sclk <= w_half_nxt[0];
                            if (!w_half_nxt[0] && (w_half_nxt != c_HALF_END)) begin
                                r_sdio_o <= r_shift[22];
                                r_shift  <= {r_shift[21:0], 1'b0};
                            end
`ifdef ADC_SPI_READBACK_EN
                            if (r_is_read && (w_half_nxt == c_DATA_HALF))
                                r_sdio_oe <= 1'b0;
                            if (r_is_read && w_half_nxt[0] && (w_half_nxt > c_DATA_HALF))
                                r_rdata <= {r_rdata[6:0], spi_sdio_i};
`endif
                        end
                    end else begin
                        r_tick <= r_tick + c_TICK_ONE;
                    end
                end
                c_GAP: begin
                    // LOAD adds one more CSB-high cycle, so the total gap is 2*SCLK_DIV.
                    if (r_tick == c_GAP_LAST) begin
                        r_tick <= '0;
                        if (r_idx == 3'd5) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= c_DONE;
                        end else if (r_idx == 3'd3) begin
`ifdef ADC_SPI_READBACK_EN
                            r_idx   <= 3'd6;
                            r_state <= c_LOAD;
`else
                            r_test_mode <= 1'b1;
                            r_align_cnt <= 24'd0;
                            r_state     <= c_WAIT_ALIGN;
`endif
`ifdef ADC_SPI_READBACK_EN
                        end else if (r_idx == 3'd6) begin
                            if (r_rdata == TEST_MODE_CODE) begin
                                r_test_mode <= 1'b1;
                                r_align_cnt <= 24'd0;
                                r_state     <= c_WAIT_ALIGN;
                            end else begin
                                r_error <= 1'b1;
                                r_idx   <= 3'd4;
                                r_state <= c_LOAD;
                            end
`endif
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= c_LOAD;
                        end
                    end else begin
                        r_tick <= r_tick + c_TICK_ONE;
                    end
                end
                c_WAIT_ALIGN: begin
                    if (dat_aligned || (w_align_nxt == ALIGN_TIMEOUT)) begin
                        if (!dat_aligned)
                            r_error <= 1'b1;
                        r_test_mode <= 1'b0;
                        r_idx       <= 3'd4;
                        r_state     <= c_LOAD;
                    end else begin
                        r_align_cnt <= w_align_nxt;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign spi_sclk     = r_sclk;
    assign spi_csb      = r_csb;
    assign spi_sdio_o   = r_sdio_o;
    assign spi_sdio_oe  = r_sdio_oe;
    assign ad_test_mode = r_test_mode;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_adc_test_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_test_pattern_ctrl
// Purpose  : Self-checking bench: decodes SPI frames and alignment handshake
//            against a frame-list model of the configuration sequence.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adc_test_pattern_ctrl;

    localparam int          D      = 2;
    localparam logic [23:0] TO     = 24'd100;
    localparam logic [7:0]  TMC    = 8'h08;
    localparam int          BUDGET = 6000;
`ifdef ADC_SPI_READBACK_EN
    localparam bit          RB     = 1'b1;
`else
    localparam bit          RB     = 1'b0;
`endif

    logic        clk_ref = 1'b0;
    logic        reset, start, dat_aligned, spi_sdio_i;
    logic [13:0] test_pattern;
    logic        spi_sclk, spi_csb, spi_sdio_o, spi_sdio_oe;
    logic        ad_test_mode, busy, done, error;

    adc_test_pattern_ctrl #(
        .SCLK_DIV       (D),
        .ALIGN_TIMEOUT  (TO),
        .TEST_MODE_CODE (TMC)
    ) dut (
        .clk_ref      (clk_ref),
        .reset        (reset),
        .start        (start),
        .test_pattern (test_pattern),
        .dat_aligned  (dat_aligned),
        .spi_sclk     (spi_sclk),
        .spi_csb      (spi_csb),
        .spi_sdio_o   (spi_sdio_o),
        .spi_sdio_oe  (spi_sdio_oe),
        .spi_sdio_i   (spi_sdio_i),
        .ad_test_mode (ad_test_mode),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk_ref = ~clk_ref;

    typedef struct {
        logic [13:0] pattern;
        int          align_delay;
        bit          pre_high;
        bit          start_in_wait;
        logic [7:0]  rb_val;
        bit          exp_error;
        int          exp_tm;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the ordered list of (R/W, address, data) writes the ADC must see.
    function automatic logic [23:0] f_frame(input bit rw, input logic [12:0] a, input logic [7:0] d);
        return {rw, 2'b00, a, d};
    endfunction

    task automatic build_expected(input logic [13:0] pat, input logic [7:0] rb_val);
        exp_q.delete();
        exp_q.push_back(f_frame(1'b0, 13'h019, {pat[5:0], 2'b00}));
        exp_q.push_back(f_frame(1'b0, 13'h01A, pat[13:6]));
        exp_q.push_back(f_frame(1'b0, 13'h00D, TMC));
        exp_q.push_back(f_frame(1'b0, 13'h0FF, 8'h01));
        if (RB) exp_q.push_back(f_frame(1'b1, 13'h00D, rb_val));
        exp_q.push_back(f_frame(1'b0, 13'h00D, 8'h00));
        exp_q.push_back(f_frame(1'b0, 13'h0FF, 8'h01));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [23:0] frames[$];
        int          lows[$], rises_q[$], gaps[$];
        logic [23:0] word;
        int low, rises, gap, tm_cnt, done_cnt, after, cyc;
        int stab_bad, oe_bad, overlap;
        bit prev_csb, prev_sclk, prev_sdio, rf, fin, err_at_done, busy_at_done, b;
        int idx4pos;

        build_expected(v.pattern, v.rb_val);
        idx4pos = RB ? 5 : 4;
        word = 24'd0; low = 0; rises = 0; gap = 0; tm_cnt = 0; done_cnt = 0; after = 0;
        stab_bad = 0; oe_bad = 0; overlap = 0; rf = 1'b0; fin = 1'b0;
        err_at_done = 1'b0; busy_at_done = 1'b1; cyc = 0;
        prev_csb = 1'b1; prev_sclk = 1'b0; prev_sdio = 1'b0;

        @(negedge clk_ref);
        test_pattern = v.pattern;
        dat_aligned  = v.pre_high;
        start        = 1'b1;
        while (!fin && cyc < BUDGET) begin
            @(negedge clk_ref);
            cyc++;
            start        = 1'b0;
            test_pattern = 14'($urandom);
            if (cyc == 1) check({tag, "/busy_after_start"}, int'(busy), 1);

            if (!spi_csb) begin
                if (prev_csb) begin
                    if (frames.size() > 0) gaps.push_back(gap);
                    low = 0; rises = 0; word = 24'd0; rf = 1'b0;
                end
                low++;
                if (spi_sdio_oe && spi_sclk && prev_sdio !== spi_sdio_o) stab_bad++;
                if (spi_sclk && !prev_sclk) begin
                    b = spi_sdio_oe ? spi_sdio_o : spi_sdio_i;
                    if (rises == 0) rf = b;
                    if (spi_sdio_oe !== !(rf && rises >= 16)) oe_bad++;
                    word = {word[22:0], b};
                    rises++;
                end
                spi_sdio_i = (rises >= 16 && rises < 24) ? v.rb_val[23 - rises] : 1'b0;
            end else begin
                if (!prev_csb) begin
                    frames.push_back(word); lows.push_back(low); rises_q.push_back(rises);
                    gap = 0;
                end
                gap++;
            end

            if (ad_test_mode) begin
                tm_cnt++;
                if (!spi_csb) overlap++;
                if (tm_cnt == v.align_delay + 1) dat_aligned = 1'b1;
                if (v.start_in_wait && tm_cnt == 5) start = 1'b1;
            end else if (tm_cnt > 0) begin
                dat_aligned = 1'b0;
            end

            if (done) begin
                done_cnt++;
                err_at_done  = error;
                busy_at_done = busy;
            end
            if (done_cnt > 0) begin
                after++;
                if (after == 2) fin = 1'b1;
            end
            prev_csb = spi_csb; prev_sclk = spi_sclk; prev_sdio = spi_sdio_o;
        end
        dat_aligned = 1'b0;
        start       = 1'b0;

        check({tag, "/finished_in_budget"}, int'(fin), 1);
        check({tag, "/frame_count"}, frames.size(), exp_q.size());
        for (int i = 0; i < frames.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s/frame%0d_word", tag, i), int'(frames[i]), int'(exp_q[i]));
            check($sformatf("%s/frame%0d_csb_low", tag, i), lows[i], 49 * D);
            check($sformatf("%s/frame%0d_sclk_rises", tag, i), rises_q[i], 24);
        end
        for (int i = 0; i < gaps.size(); i++)
            if (i + 1 != idx4pos) check($sformatf("%s/gap%0d", tag, i), gaps[i], 2 * D);
        check({tag, "/test_mode_cycles"}, tm_cnt, v.exp_tm);
        check({tag, "/error_at_done"}, int'(err_at_done), int'(v.exp_error));
        check({tag, "/done_pulses"}, done_cnt, 1);
        check({tag, "/busy_at_done"}, int'(busy_at_done), 0);
        check({tag, "/busy_after_done"}, int'(busy), 0);
        check({tag, "/sdio_unstable"}, stab_bad, 0);
        check({tag, "/oe_wrong"}, oe_bad, 0);
        check({tag, "/test_mode_during_frame"}, overlap, 0);
    endtask

    vec_t vecs[11];

    initial begin
        int d, falls, cyc;
        bit pc;
        vec_t rv;

        vecs[0] = '{14'h2867, 50,   1'b0, 1'b0, TMC, 1'b0, 51};
        vecs[1] = '{14'h2867, 1000, 1'b0, 1'b0, TMC, 1'b1, 100};
        vecs[2] = '{14'($urandom), 0,  1'b0, 1'b0, TMC, 1'b0, 1};
        vecs[3] = '{14'($urandom), 99, 1'b0, 1'b0, TMC, 1'b0, 100};
        vecs[4] = '{14'($urandom), 100, 1'b0, 1'b0, TMC, 1'b1, 100};
        vecs[5] = '{14'($urandom), 1000, 1'b1, 1'b0, TMC, 1'b0, 1};
        vecs[6] = '{14'($urandom), 30, 1'b0, 1'b1, TMC, 1'b0, 31};
        for (int i = 7; i < 11; i++) begin
            d = int'($urandom_range(0, 150));
            vecs[i] = '{14'($urandom), d, 1'b0, 1'b0, TMC, (d >= 100), (d >= 100) ? 100 : d + 1};
        end

        reset = 1'b1; start = 1'b0; dat_aligned = 1'b0; spi_sdio_i = 1'b0; test_pattern = 14'd0;
        repeat (3) @(negedge clk_ref);
        check("reset/spi_sclk", int'(spi_sclk), 0);
        check("reset/spi_csb", int'(spi_csb), 1);
        check("reset/spi_sdio_o", int'(spi_sdio_o), 0);
        check("reset/spi_sdio_oe", int'(spi_sdio_oe), 0);
        check("reset/ad_test_mode", int'(ad_test_mode), 0);
        check("reset/busy", int'(busy), 0);
        check("reset/done", int'(done), 0);
        check("reset/error", int'(error), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_ref);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during the second frame must release CSB and SCLK before the next clock edge.
        test_pattern = 14'h2867;
        start = 1'b1;
        @(negedge clk_ref);
        start = 1'b0;
        falls = 0; pc = 1'b1; cyc = 0;
        while (falls < 2 && cyc < BUDGET) begin
            @(negedge clk_ref);
            cyc++;
            if (!spi_csb && pc) falls++;
            pc = spi_csb;
        end
        check("midreset/reached_frame1", falls, 2);
        repeat (7) @(negedge clk_ref);
        check("midreset/csb_low_before", int'(spi_csb), 0);
        #2 reset = 1'b1;
        #1;
        check("midreset/csb_async", int'(spi_csb), 1);
        check("midreset/sclk_async", int'(spi_sclk), 0);
        check("midreset/busy_async", int'(busy), 0);
        @(negedge clk_ref);
        reset = 1'b0;
        @(negedge clk_ref);
        run_vec(vecs[0], "after_reset");

`ifdef ADC_SPI_READBACK_EN
        rv = '{14'h2867, 1000, 1'b0, 1'b0, 8'h00, 1'b1, 0};
        run_vec(rv, "readback_mismatch");
`else
        rv = vecs[3];
        rv.pattern = 14'h3FFF;
        run_vec(rv, "all_ones_pattern");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
